// File: rtl/bra_rs.sv
// Branch reservation station: holds dispatched branch/jump ops, wakes operands from the CDB,
// issues the oldest ready op to the branch unit and registers the unit's result one cycle later.

`ifndef ROB_ENTRY_WIDTH
`define ROB_ENTRY_WIDTH 4
`endif

module bra_rs #(
    parameter int RS_DEPTH = 4,
    parameter int TAG_W    = `ROB_ENTRY_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             disp_valid,
    output logic             disp_ready,
    input  logic [3:0]       disp_op,
    input  logic [31:0]      disp_vj,
    input  logic [31:0]      disp_vk,
    input  logic [TAG_W-1:0] disp_qj,
    input  logic [TAG_W-1:0] disp_qk,
    input  logic             disp_rj,
    input  logic             disp_rk,
    input  logic [31:0]      disp_pc,
    input  logic [31:0]      disp_offset,
    input  logic [TAG_W-1:0] disp_dest,
    input  logic             cdb_valid,
    input  logic [TAG_W-1:0] cdb_tag,
    input  logic [31:0]      cdb_val,
    input  logic             flush,
    output logic [3:0]       bra_op,
    output logic [31:0]      bra_src_a,
    output logic [31:0]      bra_src_b,
    output logic [31:0]      bra_pc,
    output logic [31:0]      bra_offset,
    output logic [TAG_W-1:0] bra_dest,
    input  logic             bra_jump_en,
    input  logic [31:0]      bra_jump_addr,
    input  logic [31:0]      bra_dest_val,
    output logic             res_valid,
    output logic [TAG_W-1:0] res_tag,
    output logic             res_jump_en,
    output logic [31:0]      res_jump_addr,
    output logic [31:0]      res_link
);

    localparam int IDX_W = (RS_DEPTH > 1) ? $clog2(RS_DEPTH) : 1;
    localparam int CNT_W = IDX_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(RS_DEPTH);

    typedef struct packed {
        logic             valid;
        logic [3:0]       op;
        logic [31:0]      vj;
        logic [31:0]      vk;
        logic [TAG_W-1:0] qj;
        logic [TAG_W-1:0] qk;
        logic             rj;
        logic             rk;
        logic [31:0]      pc;
        logic [31:0]      offset;
        logic [TAG_W-1:0] dest;
        logic [IDX_W-1:0] rank;
    } entry_t;

    entry_t           ent [RS_DEPTH];
    logic [CNT_W-1:0] occ;

    logic             sel_found;
    logic [IDX_W-1:0] sel_idx;
    logic [IDX_W-1:0] sel_rank;
    logic [IDX_W-1:0] free_idx;
    logic             do_alloc;
    logic             do_issue;
    logic             bypass_j;
    logic             bypass_k;
    entry_t           new_ent;
    logic [CNT_W-1:0] valid_count;

    // Dispatch handshake: an op transfers on a rising edge where disp_valid && disp_ready.
    // disp_ready depends only on registered occupancy, so an issue in the same cycle never frees a slot.
    assign disp_ready = (occ < DEPTH_C);

    assign do_alloc = disp_valid && disp_ready && (disp_op != 4'd0) && !flush;
    assign do_issue = sel_found && !flush;

    // Oldest ready entry: ranks are unique, so the minimum rank among candidates is the winner.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        sel_rank  = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            if (ent[i].valid && ent[i].rj && ent[i].rk &&
                (!sel_found || (ent[i].rank < sel_rank))) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(i);
                sel_rank  = ent[i].rank;
            end
        end
    end

    always_comb begin
        free_idx = '0;
        for (int i = RS_DEPTH - 1; i >= 0; i--) begin
            if (!ent[i].valid) begin
                free_idx = IDX_W'(i);
            end
        end
    end

    // A CDB broadcast in the dispatch cycle is captured directly into the new entry.
    always_comb begin
        bypass_j       = cdb_valid && !disp_rj && (cdb_tag == disp_qj);
        bypass_k       = cdb_valid && !disp_rk && (cdb_tag == disp_qk);
        new_ent        = '0;
        new_ent.valid  = 1'b1;
        new_ent.op     = disp_op;
        new_ent.vj     = bypass_j ? cdb_val : disp_vj;
        new_ent.vk     = bypass_k ? cdb_val : disp_vk;
        new_ent.qj     = disp_qj;
        new_ent.qk     = disp_qk;
        new_ent.rj     = disp_rj | bypass_j;
        new_ent.rk     = disp_rk | bypass_k;
        new_ent.pc     = disp_pc;
        new_ent.offset = disp_offset;
        new_ent.dest   = disp_dest;
        new_ent.rank   = do_issue ? IDX_W'(occ - CNT_W'(1)) : IDX_W'(occ);
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flush) begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                ent[i].valid <= 1'b0;
            end
            occ <= '0;
        end else begin
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ent[i].valid) begin
                    if (cdb_valid && !ent[i].rj && (ent[i].qj == cdb_tag)) begin
                        ent[i].vj <= cdb_val;
                        ent[i].rj <= 1'b1;
                    end
                    if (cdb_valid && !ent[i].rk && (ent[i].qk == cdb_tag)) begin
                        ent[i].vk <= cdb_val;
                        ent[i].rk <= 1'b1;
                    end
                    // Younger entries close the gap left by the issued one.
                    if (do_issue && (IDX_W'(i) == sel_idx)) begin
                        ent[i].valid <= 1'b0;
                    end else if (do_issue && (ent[i].rank > sel_rank)) begin
                        ent[i].rank <= ent[i].rank - IDX_W'(1);
                    end
                end
            end
            if (do_alloc) begin
                ent[free_idx] <= new_ent;
            end
            occ <= occ + CNT_W'(do_alloc) - CNT_W'(do_issue);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bra_op        <= '0;
            bra_src_a     <= '0;
            bra_src_b     <= '0;
            bra_pc        <= '0;
            bra_offset    <= '0;
            bra_dest      <= '0;
            res_valid     <= 1'b0;
            res_tag       <= '0;
            res_jump_en   <= 1'b0;
            res_jump_addr <= '0;
            res_link      <= '0;
        end else if (flush) begin
            bra_op    <= '0;
            res_valid <= 1'b0;
        end else begin
            if (do_issue) begin
                bra_op     <= ent[sel_idx].op;
                bra_src_a  <= ent[sel_idx].vj;
                bra_src_b  <= ent[sel_idx].vk;
                bra_pc     <= ent[sel_idx].pc;
                bra_offset <= ent[sel_idx].offset;
                bra_dest   <= ent[sel_idx].dest;
            end else begin
                bra_op <= '0;
            end
            res_valid <= (bra_op != 4'd0);
            if (bra_op != 4'd0) begin
                res_tag       <= bra_dest;
                res_jump_en   <= bra_jump_en;
                res_jump_addr <= bra_jump_addr;
                res_link      <= bra_dest_val;
            end
        end
    end

    // Occupancy must match the valid bits, and valid ranks must stay below occupancy.
    always_comb begin
        valid_count = '0;
        for (int i = 0; i < RS_DEPTH; i++) begin
            valid_count = valid_count + CNT_W'(ent[i].valid);
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (occ == valid_count);
            for (int i = 0; i < RS_DEPTH; i++) begin
                if (ent[i].valid) begin
                    assert (CNT_W'(ent[i].rank) < occ);
                end
            end
        end
    end

endmodule

// File: tb/tb_bra_rs.sv
// Bench for bra_rs: age-ordered queue model of the station plus a small branch unit,
// checked every cycle, with literal expectations pinning the directed scenarios.

module tb_bra_rs;

    localparam int TW    = 4;
    localparam int DEPTH = 4;

    localparam logic [3:0] BEQ  = 4'd1;
    localparam logic [3:0] BNE  = 4'd2;
    localparam logic [3:0] BLT  = 4'd3;
    localparam logic [3:0] BGE  = 4'd4;
    localparam logic [3:0] BLTU = 4'd5;
    localparam logic [3:0] BGEU = 4'd6;
    localparam logic [3:0] JAL  = 4'd7;
    localparam logic [3:0] JALR = 4'd8;

    logic          clk;
    logic          rst_n;
    logic          disp_valid;
    logic          disp_ready;
    logic [3:0]    disp_op;
    logic [31:0]   disp_vj, disp_vk;
    logic [TW-1:0] disp_qj, disp_qk;
    logic          disp_rj, disp_rk;
    logic [31:0]   disp_pc, disp_offset;
    logic [TW-1:0] disp_dest;
    logic          cdb_valid;
    logic [TW-1:0] cdb_tag;
    logic [31:0]   cdb_val;
    logic          flush;
    logic [3:0]    bra_op;
    logic [31:0]   bra_src_a, bra_src_b, bra_pc, bra_offset;
    logic [TW-1:0] bra_dest;
    logic          bra_jump_en;
    logic [31:0]   bra_jump_addr, bra_dest_val;
    logic          res_valid;
    logic [TW-1:0] res_tag;
    logic          res_jump_en;
    logic [31:0]   res_jump_addr, res_link;

    int tests;
    int fails;

    bra_rs #(.RS_DEPTH(DEPTH), .TAG_W(TW)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_ready(disp_ready), .disp_op(disp_op),
        .disp_vj(disp_vj), .disp_vk(disp_vk), .disp_qj(disp_qj), .disp_qk(disp_qk),
        .disp_rj(disp_rj), .disp_rk(disp_rk), .disp_pc(disp_pc), .disp_offset(disp_offset),
        .disp_dest(disp_dest),
        .cdb_valid(cdb_valid), .cdb_tag(cdb_tag), .cdb_val(cdb_val),
        .flush(flush),
        .bra_op(bra_op), .bra_src_a(bra_src_a), .bra_src_b(bra_src_b), .bra_pc(bra_pc),
        .bra_offset(bra_offset), .bra_dest(bra_dest),
        .bra_jump_en(bra_jump_en), .bra_jump_addr(bra_jump_addr), .bra_dest_val(bra_dest_val),
        .res_valid(res_valid), .res_tag(res_tag), .res_jump_en(res_jump_en),
        .res_jump_addr(res_jump_addr), .res_link(res_link)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // ---------------- branch unit: {taken, target, link} ----------------
    function automatic logic [64:0] bu_eval(input logic [3:0] op, input logic [31:0] a,
                                            input logic [31:0] b, input logic [31:0] pc,
                                            input logic [31:0] off);
        logic en;
        logic [31:0] addr;
        case (op)
            BEQ:     en = (a == b);
            BNE:     en = (a != b);
            BLT:     en = ($signed(a) < $signed(b));
            BGE:     en = ($signed(a) >= $signed(b));
            BLTU:    en = (a < b);
            BGEU:    en = (a >= b);
            JAL:     en = 1'b1;
            JALR:    en = 1'b1;
            default: en = 1'b0;
        endcase
        addr = (op == JALR) ? (a + off) : (pc + off);
        return {en, addr, pc + 32'd4};
    endfunction

    always_comb begin
        {bra_jump_en, bra_jump_addr, bra_dest_val} = bu_eval(bra_op, bra_src_a, bra_src_b,
                                                             bra_pc, bra_offset);
    end

    // ---------------- behavioural model ----------------
    typedef struct {
        logic [3:0]    op;
        logic [31:0]   vj, vk, pc, off;
        logic [TW-1:0] qj, qk, dest;
        logic          rj, rk;
    } m_ent_t;

    m_ent_t        m_q[$];
    m_ent_t        m_e;
    logic [TW-1:0] exp_q[$];
    int            m_pick;
    logic          m_full;
    logic [3:0]    m_bra_op;
    logic [31:0]   m_bra_a, m_bra_b, m_bra_pc, m_bra_off;
    logic [TW-1:0] m_bra_dest;
    logic          m_res_valid, m_res_en;
    logic [TW-1:0] m_res_tag;
    logic [31:0]   m_res_addr, m_res_link;

    task automatic model_step();
        if (!rst_n) begin
            m_q.delete();
            exp_q.delete();
            m_bra_op = '0; m_bra_a = '0; m_bra_b = '0; m_bra_pc = '0; m_bra_off = '0;
            m_bra_dest = '0;
            m_res_valid = 1'b0; m_res_en = 1'b0; m_res_tag = '0; m_res_addr = '0;
            m_res_link = '0;
        end else if (flush) begin
            m_q.delete();
            exp_q.delete();
            m_bra_op = '0;
            m_res_valid = 1'b0;
        end else begin
            m_res_valid = (m_bra_op != 4'd0);
            if (m_res_valid) begin
                m_res_tag = m_bra_dest;
                {m_res_en, m_res_addr, m_res_link} = bu_eval(m_bra_op, m_bra_a, m_bra_b,
                                                             m_bra_pc, m_bra_off);
            end
            m_full = (m_q.size() >= DEPTH);
            m_pick = -1;
            for (int i = 0; i < m_q.size(); i++) begin
                if (m_pick < 0 && m_q[i].rj && m_q[i].rk) m_pick = i;
            end
            if (m_pick >= 0) begin
                m_e = m_q[m_pick];
                m_bra_op = m_e.op; m_bra_a = m_e.vj; m_bra_b = m_e.vk;
                m_bra_pc = m_e.pc; m_bra_off = m_e.off; m_bra_dest = m_e.dest;
                exp_q.push_back(m_e.dest);
                m_q.delete(m_pick);
            end else begin
                m_bra_op = '0;
            end
            for (int i = 0; i < m_q.size(); i++) begin
                m_e = m_q[i];
                if (cdb_valid && !m_e.rj && m_e.qj == cdb_tag) begin m_e.vj = cdb_val; m_e.rj = 1'b1; end
                if (cdb_valid && !m_e.rk && m_e.qk == cdb_tag) begin m_e.vk = cdb_val; m_e.rk = 1'b1; end
                m_q[i] = m_e;
            end
            if (disp_valid && !m_full && disp_op != 4'd0) begin
                m_e.op = disp_op; m_e.pc = disp_pc; m_e.off = disp_offset; m_e.dest = disp_dest;
                m_e.qj = disp_qj; m_e.qk = disp_qk;
                m_e.rj = disp_rj; m_e.rk = disp_rk; m_e.vj = disp_vj; m_e.vk = disp_vk;
                if (cdb_valid && !disp_rj && disp_qj == cdb_tag) begin m_e.vj = cdb_val; m_e.rj = 1'b1; end
                if (cdb_valid && !disp_rk && disp_qk == cdb_tag) begin m_e.vk = cdb_val; m_e.rk = 1'b1; end
                m_q.push_back(m_e);
            end
        end
    endtask

    initial forever begin
        @(posedge clk);
        model_step();
    end

    // ---------------- scoreboard ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare();
        if (rst_n) begin
            check("disp_ready", 32'(disp_ready), 32'(m_q.size() < DEPTH));
            check("bra_op", 32'(bra_op), 32'(m_bra_op));
            if (m_bra_op != 4'd0) begin
                check("bra_src_a", bra_src_a, m_bra_a);
                check("bra_src_b", bra_src_b, m_bra_b);
                check("bra_pc", bra_pc, m_bra_pc);
                check("bra_offset", bra_offset, m_bra_off);
                check("bra_dest", 32'(bra_dest), 32'(m_bra_dest));
            end
            check("res_valid", 32'(res_valid), 32'(m_res_valid));
            if (m_res_valid) begin
                check("res_tag", 32'(res_tag), 32'(m_res_tag));
                check("res_jump_en", 32'(res_jump_en), 32'(m_res_en));
                check("res_jump_addr", res_jump_addr, m_res_addr);
                check("res_link", res_link, m_res_link);
            end
            if (res_valid) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL sb_unexpected_result: actual tag=%0h required=none at %0t",
                             res_tag, $time);
                end else begin
                    check("sb_tag", 32'(res_tag), 32'(exp_q.pop_front()));
                end
            end
        end
    endtask

    initial forever begin
        @(negedge clk);
        compare();
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        disp_valid = 1'b0; disp_op = '0; disp_vj = '0; disp_vk = '0; disp_qj = '0; disp_qk = '0;
        disp_rj = 1'b0; disp_rk = 1'b0; disp_pc = '0; disp_offset = '0; disp_dest = '0;
        cdb_valid = 1'b0; cdb_tag = '0; cdb_val = '0; flush = 1'b0;
    endtask

    task automatic disp(input logic [3:0] op, input logic [31:0] vj, input logic [31:0] vk,
                        input logic [TW-1:0] qj, input logic [TW-1:0] qk, input logic rj,
                        input logic rk, input logic [31:0] pc, input logic [31:0] off,
                        input logic [TW-1:0] dest);
        disp_valid = 1'b1; disp_op = op; disp_vj = vj; disp_vk = vk; disp_qj = qj; disp_qk = qk;
        disp_rj = rj; disp_rk = rk; disp_pc = pc; disp_offset = off; disp_dest = dest;
    endtask

    task automatic cdb(input logic [TW-1:0] tag, input logic [31:0] val);
        cdb_valid = 1'b1; cdb_tag = tag; cdb_val = val;
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // ---------------- stimulus ----------------
    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        idle();
        repeat (2) tick();
        check("rst_disp_ready", 32'(disp_ready), 32'd1);
        check("rst_bra_op", 32'(bra_op), 32'd0);
        check("rst_bra_src_a", bra_src_a, 32'd0);
        check("rst_bra_dest", 32'(bra_dest), 32'd0);
        check("rst_res_valid", 32'(res_valid), 32'd0);
        check("rst_res_jump_addr", res_jump_addr, 32'd0);
        rst_n = 1'b1;
        tick();

        // ready issue
        disp(BEQ, 32'd5, 32'd5, 4'd0, 4'd0, 1'b1, 1'b1, 32'h100, 32'h20, 4'd3);
        tick(); idle();
        tick();
        check("ready_bra_op", 32'(bra_op), 32'(BEQ));
        check("ready_bra_dest", 32'(bra_dest), 32'd3);
        tick();
        check("ready_res_valid", 32'(res_valid), 32'd1);
        check("ready_res_tag", 32'(res_tag), 32'd3);
        check("ready_res_jump_en", 32'(res_jump_en), 32'd1);
        check("ready_res_jump_addr", res_jump_addr, 32'h120);
        check("ready_res_link", res_link, 32'h104);
        tick();
        check("ready_res_pulse", 32'(res_valid), 32'd0);

        // CDB wake-up
        disp(BNE, 32'd0, 32'd9, 4'd2, 4'd0, 1'b0, 1'b1, 32'h200, 32'h10, 4'd5);
        tick(); idle();
        tick(); tick();
        check("wake_wait", 32'(bra_op), 32'd0);
        cdb(4'd2, 32'd7);
        tick(); idle();
        check("wake_not_same_edge", 32'(bra_op), 32'd0);
        tick();
        check("wake_bra_op", 32'(bra_op), 32'(BNE));
        check("wake_src_a", bra_src_a, 32'd7);
        tick();
        check("wake_res_jump_en", 32'(res_jump_en), 32'd1);
        check("wake_res_jump_addr", res_jump_addr, 32'h210);

        // age order
        disp(BEQ, 32'd0, 32'd3, 4'd4, 4'd0, 1'b0, 1'b1, 32'h400, 32'h40, 4'd1);
        tick();
        disp(BLT, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 32'h500, 32'h8, 4'd2);
        tick(); idle();
        cdb(4'd4, 32'd3);
        tick(); idle();
        check("age_first", 32'(bra_dest), 32'd2);
        tick();
        check("age_second", 32'(bra_dest), 32'd1);
        check("age_second_src_a", bra_src_a, 32'd3);
        tick(); tick();

        // full station
        for (int k = 0; k < 4; k++) begin
            disp(BGE, 32'd0, 32'd0, TW'(8 + k), 4'd0, 1'b0, 1'b1, 32'h600 + 32'(k * 16), 32'd4,
                 TW'(4 + k));
            tick();
        end
        idle();
        check("full_not_ready", 32'(disp_ready), 32'd0);
        disp(BEQ, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 32'h700, 32'd0, 4'd12);
        tick(); idle();
        check("full_still_not_ready", 32'(disp_ready), 32'd0);
        tick();
        check("full_dropped", 32'(bra_op), 32'd0);
        cdb(4'd8, 32'd5);
        tick(); idle();
        disp(BEQ, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 32'h780, 32'd0, 4'd13);
        tick(); idle();
        check("full_issue_dest", 32'(bra_dest), 32'd4);
        check("full_ready_after_issue", 32'(disp_ready), 32'd1);
        tick();
        check("full_same_cycle_dropped", 32'(bra_op), 32'd0);

        // flush with 3 entries and an op in the issue register
        disp(BLTU, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 32'h800, 32'h10, 4'd13);
        tick(); idle();
        tick();
        check("flush_pre_bra_op", 32'(bra_op), 32'(BLTU));
        flush = 1'b1;
        disp(BEQ, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 32'h880, 32'd0, 4'd14);
        tick(); idle();
        check("flush_bra_op", 32'(bra_op), 32'd0);
        check("flush_res_valid", 32'(res_valid), 32'd0);
        check("flush_disp_ready", 32'(disp_ready), 32'd1);
        tick();
        check("flush_disp_dropped", 32'(bra_op), 32'd0);
        cdb(4'd9, 32'd0);
        tick(); idle();
        tick();
        check("flush_entries_gone", 32'(bra_op), 32'd0);

        // dispatch bypass
        disp(BEQ, 32'd9, 32'd0, 4'd0, 4'd6, 1'b1, 1'b0, 32'h900, 32'h30, 4'd6);
        cdb(4'd6, 32'd9);
        tick(); idle();
        check("bypass_not_same_edge", 32'(bra_op), 32'd0);
        tick();
        check("bypass_bra_op", 32'(bra_op), 32'(BEQ));
        check("bypass_src_b", bra_src_b, 32'd9);
        tick();
        check("bypass_res_jump_addr", res_jump_addr, 32'h930);

        // back-to-back dispatch and issue, jumps, unsigned/signed compares, op 0 dropped
        disp(JALR, 32'h1000, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 32'h300, 32'h8, 4'd1);
        tick();
        disp(JAL, 32'd0, 32'd0, 4'd0, 4'd0, 1'b1, 1'b1, 32'h340, 32'h100, 4'd2);
        tick();
        check("jalr_bra_op", 32'(bra_op), 32'(JALR));
        check("jalr_src_a", bra_src_a, 32'h1000);
        disp(BGEU, 32'hFFFF_FFFF, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 32'h380, 32'h4, 4'd3);
        tick();
        check("jalr_res_addr", res_jump_addr, 32'h1008);
        check("jalr_res_link", res_link, 32'h304);
        check("jal_bra_op", 32'(bra_op), 32'(JAL));
        disp(BLT, 32'hFFFF_FFFF, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 32'h3C0, 32'h8, 4'd4);
        tick();
        disp(BLTU, 32'hFFFF_FFFF, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 32'h3E0, 32'h8, 4'd5);
        tick();
        disp(BNE, 32'd3, 32'd3, 4'd0, 4'd0, 1'b1, 1'b1, 32'h3F0, 32'h8, 4'd6);
        tick();
        disp(4'd0, 32'd1, 32'd1, 4'd0, 4'd0, 1'b1, 1'b1, 32'h3F8, 32'h8, 4'd7);
        tick(); idle();
        tick();
        check("op0_dropped", 32'(bra_op), 32'd0);
        tick(); tick();

        // reset mid-operation
        disp(BEQ, 32'd0, 32'd0, 4'd12, 4'd0, 1'b0, 1'b1, 32'hA00, 32'h4, 4'd8);
        tick();
        disp(BEQ, 32'd0, 32'd0, 4'd13, 4'd0, 1'b0, 1'b1, 32'hA10, 32'h4, 4'd9);
        tick();
        disp(BNE, 32'd1, 32'd2, 4'd0, 4'd0, 1'b1, 1'b1, 32'hA20, 32'h4, 4'd10);
        tick(); idle();
        tick();
        check("mid_rst_pre_bra_op", 32'(bra_op), 32'(BNE));
        rst_n = 1'b0;
        tick();
        check("mid_rst_bra_op", 32'(bra_op), 32'd0);
        check("mid_rst_bra_src_a", bra_src_a, 32'd0);
        check("mid_rst_res_valid", 32'(res_valid), 32'd0);
        check("mid_rst_res_tag", 32'(res_tag), 32'd0);
        check("mid_rst_disp_ready", 32'(disp_ready), 32'd1);
        rst_n = 1'b1;
        cdb(4'd12, 32'd0);
        tick(); idle();
        tick();
        check("mid_rst_entries_gone", 32'(bra_op), 32'd0);

        // refill to full, then drain in wake order
        for (int k = 1; k <= 4; k++) begin
            disp(BGEU, 32'd0, 32'd4, TW'(k), 4'd0, 1'b0, 1'b1, 32'hB00 + 32'(k * 4), 32'h40,
                 TW'(k + 10));
            tick();
        end
        idle();
        check("refill_full", 32'(disp_ready), 32'd0);
        for (int k = 4; k >= 1; k--) begin
            cdb(TW'(k), 32'(k));
            tick();
        end
        idle();
        repeat (4) tick();
        check("drain_sb_empty", 32'(exp_q.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
